// File: rtl/alu_pkg.sv
// Shared encodings for the serial ALU: operation codes and FSM states.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic op_is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_XOR;
    endfunction

endpackage

// File: rtl/alu_chunk.sv
// Combinational CHUNK-bit slice of the ALU. For SUB the caller presents an
// already inverted y and cin=1, so ADD and SUB share the same adder.
module alu_chunk
    import alu_pkg::*;
#(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] x_i,
    input  logic [CHUNK-1:0] y_i,
    input  logic             cin_i,
    input  logic [2:0]       op_i,
    output logic [CHUNK-1:0] r_o,
    output logic             cout_o,
    output logic             msb_cin_o
);

    logic [CHUNK:0] sum_s;

    assign sum_s = {1'b0, x_i} + {1'b0, y_i} + {{CHUNK{1'b0}}, cin_i};

    // Operation select; the MSB carry-in is recovered from the sum bit.
    always_comb begin
        r_o       = {CHUNK{1'b0}};
        cout_o    = 1'b0;
        msb_cin_o = 1'b0;
        case (op_i)
            OP_ADD, OP_SUB: begin
                r_o       = sum_s[CHUNK-1:0];
                cout_o    = sum_s[CHUNK];
                msb_cin_o = x_i[CHUNK-1] ^ y_i[CHUNK-1] ^ sum_s[CHUNK-1];
            end
            OP_AND:  r_o = x_i & y_i;
            OP_XOR:  r_o = x_i ^ y_i;
            default: r_o = {CHUNK{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// Multi-cycle integer ALU: CHUNK bits per cycle, LSB first, behind a
// valid/ready handshake. Result and flags only change on completion.
module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic             err
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $error("alu_serial: WIDTH must be a positive multiple of CHUNK");
    end

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
    logic             carry_q, carry_d, allz_q, allz_d;
    logic             cout_q, cout_d, zf_q, zf_d, sf_q, sf_d, of_q, of_d, err_q, err_d;
    logic             out_valid_q, out_valid_d, in_ready_q, in_ready_d;

    logic [31:0]       sh_s;
    logic [CHUNK-1:0]  x_s, y_s, r_s;
    logic              c_s, msb_cin_s;
    logic [WIDTH-1:0]  acc_upd_s;
    logic              allz_upd_s;

    assign sh_s = 32'(cnt_q) * 32'(CHUNK);
    assign x_s  = CHUNK'(a_q >> sh_s);
    assign y_s  = CHUNK'(b_q >> sh_s);

    alu_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x_i       (x_s),
        .y_i       (y_s),
        .cin_i     (carry_q),
        .op_i      (op_q),
        .r_o       (r_s),
        .cout_o    (c_s),
        .msb_cin_o (msb_cin_s)
    );

    // The accumulator is cleared on accept, so OR-ing each chunk in is enough.
    assign acc_upd_s  = acc_q | (WIDTH'(r_s) << sh_s);
    assign allz_upd_s = allz_q & (r_s == {CHUNK{1'b0}});

    // FSM, operand latching and flag computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        allz_d      = allz_q;
        result_d    = result_q;
        cout_d      = cout_q;
        zf_d        = zf_q;
        sf_d        = sf_q;
        of_d        = of_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = (op == OP_SUB) ? ~b : b;
                    carry_d = (op == OP_SUB);
                    acc_d   = {WIDTH{1'b0}};
                    allz_d  = 1'b1;
                    cnt_d   = {CW{1'b0}};
                    state_d = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                acc_d   = acc_upd_s;
                carry_d = c_s;
                allz_d  = allz_upd_s;
                if (cnt_q == LAST) begin
                    result_d = acc_upd_s;
                    zf_d     = allz_upd_s;
                    sf_d     = r_s[CHUNK-1];
                    cout_d   = op_is_arith(op_q) & c_s;
                    // Signed overflow: carry into the MSB differs from carry out.
                    of_d     = op_is_arith(op_q) & (c_s ^ msb_cin_s);
                    err_d    = ~op_is_legal(op_q);
                    cnt_d    = {CW{1'b0}};
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        out_valid_d = (state_d == S_DONE);
        in_ready_d  = (state_d == S_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CW{1'b0}};
            op_q        <= 3'd0;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            acc_q       <= {WIDTH{1'b0}};
            carry_q     <= 1'b0;
            allz_q      <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            cout_q      <= 1'b0;
            zf_q        <= 1'b0;
            sf_q        <= 1'b0;
            of_q        <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            allz_q      <= allz_d;
            result_q    <= result_d;
            cout_q      <= cout_d;
            zf_q        <= zf_d;
            sf_q        <= sf_d;
            of_q        <= of_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign cout      = cout_q;
    assign zf        = zf_q;
    assign sf        = sf_q;
    assign of        = of_q;
    assign err       = err_q;

endmodule

// File: doc/alu_serial.md
Name: alu_serial

Overview:
- Parametrised multi-cycle integer ALU: successor to the fixed 64-bit combinational add/subtract units.
- Processes operands CHUNK bits per cycle, LSB first, through one shared chunk adder.
- Produces the result, carry, and Y86-style condition codes (ZF, SF, OF).
- Sits in the execute stage behind a valid/ready handshake, so the stage stalls while it is busy.

Parameters:
- WIDTH, 64: operand/result width in bits.
- CHUNK, 16: bits processed per cycle. WIDTH % CHUNK == 0 and CHUNK >= 1 are required; elaboration fails otherwise.
- NCHUNK, WIDTH/CHUNK: derived localparam, the number of busy cycles.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- op  in  3  0=ADD, 1=SUB (a-b), 2=AND, 3=XOR, 4..7 illegal
- a  in  WIDTH  first operand, two's complement
- b  in  WIDTH  second operand, two's complement
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- result  out  WIDTH  a op b, modulo 2^WIDTH
- cout  out  1  carry out of MSB (ADD/SUB only; SUB carry = NOT borrow)
- zf  out  1  result == 0
- sf  out  1  result[WIDTH-1]
- of  out  1  signed overflow
- err  out  1  illegal op code

Behaviour:
- States:
  - IDLE: in_ready=1.
  - BUSY: chunk counter cnt runs 0..NCHUNK-1.
  - DONE: out_valid=1.
- Reset (async, active-high): state=IDLE, cnt=0, all of result/cout/zf/sf/of/err/out_valid=0. A reset asserted mid-operation aborts the operation with no partial result visible. in_ready=1 once reset is released.
- Accept: on a clk edge with in_valid&&in_ready, latch op, a, and b (b inverted for SUB), set carry=1 for SUB and 0 otherwise, cnt=0, go to BUSY. Inputs are don't-care at all other times.
- BUSY edge: chunk cnt is computed from the latched operands plus the carry register and written into result[cnt*CHUNK +: CHUNK]; carry is updated; cnt increments.
- The edge that processes chunk NCHUNK-1 also:
  - registers cout, zf, sf, of;
  - sets out_valid=1 and goes to DONE.
- Latency: out_valid rises at edge T+NCHUNK, where T is the accept edge. Example: 4 cycles at the defaults. NCHUNK=1 gives a 1-cycle latency.
- DONE: result and flags are held stable until out_valid&&out_ready at an edge, then go to IDLE with out_valid=0. The next accept is possible on the following edge. Throughput is one op per NCHUNK+2 cycles with out_ready held at 1.
- in_ready is 0 in BUSY and DONE; in_valid is ignored there.
- Overflow rules (s = sign bit):
  - ADD: of = (sa==sb) && (sr!=sa).
  - SUB: of = (sa!=sb) && (sr!=sa).
  - AND/XOR: of=0, cout=0.
- zf must reflect the full WIDTH result. Accumulate a running "all chunks zero" flag; do not compare a partial register.
- Illegal op: the handshake completes with normal latency; result=0, zf=1, sf=of=cout=0, err=1. err=0 for legal ops.
- Flags are valid only while out_valid=1. They retain their last value in IDLE until the next completion or reset.

Decomposition:
- Shared package alu_pkg holds:
  - op encodings OP_ADD=3'd0, OP_SUB=3'd1, OP_AND=3'd2, OP_XOR=3'd3;
  - state encodings S_IDLE, S_BUSY, S_DONE.
- One natural sub-module: alu_chunk. It is combinational CHUNK-bit logic with inputs x, y, cin, op and outputs r, cout, plus the MSB carry-in needed for the overflow cross-check.
- alu_serial holds the FSM, operand/result registers, counter, and flag logic.

Test Plan:
- Basic ADD and SUB, WIDTH=64, CHUNK=16:
  - op=ADD, a=54, b=46 -> result=100, zf=sf=of=0. out_valid rises exactly 4 edges after accept, and in_ready=0 during that time.
  - op=SUB, a=54, b=46 -> result=8, cout=1, of=0.
- Signed mixes:
  - SUB a=-1, b=10 -> result=-11, sf=1, of=0.
  - SUB a=1000, b=-15 -> 1015.
  - SUB a=-455, b=-45 -> -410, sf=1.
- Overflow and zero:
  - SUB a=1<<63, b=1<<62 -> result=64'h4000_0000_0000_0000, of=1.
  - SUB a=1<<62, b=3<<62 -> result=64'h8000_0000_0000_0000, sf=1, of=1.
  - ADD a=-1, b=1 -> result=0, zf=1, cout=1, of=0.
- Handshake, logic ops and illegal op:
  - Hold out_ready=0 for 5 cycles after out_valid -> result is stable and in_ready stays 0. Pulse out_ready -> IDLE on the next edge.
  - XOR a=b=64'hDEAD -> 0, zf=1.
  - op=5 -> err=1, result=0.
- Reset and parameter sweep:
  - Assert rst asynchronously during BUSY cycle 2 -> out_valid=0, result=0, in_ready=1 immediately after release. A new ADD 54+46 then completes correctly.
  - Re-run the ADD/SUB and overflow cases with (WIDTH=64, CHUNK=64), (32, 8), (8, 1); check latency = WIDTH/CHUNK each time.
